cv32e40n_apu_arbiter: RTL and testbench
=======================================

CV32E40N_APU_ARBITER -- requirements
Module: cv32e40n_apu_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning max outstanding APU transactions (power of two, >=2).
REQ-002 SHALL have ports, clock and reset first:
- clk_i  in  1  clock
- rst_i  in  1  async active-high reset
- req_operands_i  in  [2][APU_NARGS_CPU][32]  per-requester operands
- req_op_i  in  [2][APU_WOP_CPU]  per-requester opcode
- req_flags_i  in  [2][APU_NDSFLAGS_CPU]  per-requester flags
- req_req_i  in  [2]  request valid
- req_gnt_o  out  [2]  request accepted
- req_rvalid_o  out  [2]  result valid to the owner
- req_result_o  out  32  shared result bus
- req_flags_o  out  APU_NUSFLAGS_CPU  shared result flags
- apu_operands_o / apu_op_o / apu_flags_o / apu_req_o  out  matching widths  downstream request
- apu_gnt_i  in  1  downstream grant
- apu_rvalid_i / apu_result_i / apu_flags_i  in  1 / 32 / APU_NUSFLAGS_CPU  downstream response
- spurious_o  out  1  sticky: rvalid with nothing outstanding
- timeout_o  out  1  sticky watchdog flag (Configuration)

Function
REQ-003 SHALL share one APU between requesters 0 and 1; transfer occurs in the cycle where req and gnt are both high.
REQ-004 SHALL drive apu_req_o = 1 only when some req_req_i is high and the ID FIFO is not full; otherwise 0.
REQ-005 SHALL select the winner combinationally: single requester wins; if both request, the requester not granted last wins (round-robin); after reset, requester 0 has priority.
REQ-006 SHALL mux winner's operands/op/flags onto apu_*_o; when apu_req_o = 0 those outputs SHALL be 0.
REQ-007 SHALL assert req_gnt_o[winner] = apu_gnt_i && apu_req_o; loser's gnt SHALL be 0; request-to-grant latency is zero cycles beyond apu_gnt_i.
REQ-008 SHALL, on each accepted transfer, push the winner ID into an in-order ID FIFO and update the last-granted pointer.
REQ-009 SHALL, on apu_rvalid_i with FIFO non-empty, pop the head and assert req_rvalid_o[head] in the same cycle; req_result_o/req_flags_o pass apu_result_i/apu_flags_i through.
REQ-010 SHALL treat FIFO full as blocking: no grant while full, even if a pop occurs that cycle.
REQ-011 SHALL permit push and pop in the same cycle when not full; occupancy unchanged.
REQ-012 SHALL wrap read/write pointers modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer bit.
REQ-013 SHALL, on apu_rvalid_i with FIFO empty, set spurious_o, assert no req_rvalid_o, leave pointers unchanged.

Reset
REQ-014 SHALL, on rst_i asserted at any time, asynchronously clear FIFO pointers, set last-granted to requester 1 (so 0 wins next tie), clear spurious_o, timeout_o and the watchdog counter; in-flight transactions are discarded.
REQ-015 SHALL hold all registered outputs 0 and req_gnt_o = 0 while rst_i is high.

Configuration
REQ-016 SHALL compile a response watchdog under macro CV32E40N_APU_ARB_TIMEOUT_EN.
REQ-017 With the macro: counter increments each cycle FIFO is non-empty and apu_rvalid_i is low, clears on apu_rvalid_i or empty; on reaching APU_ARB_TIMEOUT_CYCLES, timeout_o SHALL set and stay high until reset.
REQ-018 Without the macro: timeout_o SHALL be tied 0 and no counter SHALL exist.

Structure
REQ-019 SHALL place APU_ARB_TIMEOUT_CYCLES (default 255) and the requester-ID typedef (1 bit) in cv32e40p_apu_core_pkg, reusing its APU_* width constants.
REQ-020 SHALL implement the ID FIFO as sub-module cv32e40n_apu_arb_id_fifo (push, pop, full, empty, head).

Verification
REQ-021 Bench SHALL cover:
- Req0 only, apu_gnt_i=1, rvalid 2 cycles later -> gnt[0] in cycle 0, rvalid[0] in cycle 2, result 0xDEADBEEF forwarded.
- Both requesting continuously, gnt always 1, rvalid 2 cycles later -> grants alternate 0,1,0,1 from reset.
- 4 grants with no rvalid (FIFO_DEPTH=4) -> 5th request not granted, apu_req_o=0; one rvalid -> rvalid[0], grant resumes next cycle.
- apu_rvalid_i with nothing outstanding -> spurious_o=1, no req_rvalid_o, stays 1 until rst_i.
- Macro on, one grant, no rvalid for 255 cycles -> timeout_o=1 in cycle 255; macro off -> timeout_o stays 0.
- rst_i asserted with 3 outstanding -> FIFO empty, subsequent tie grants requester 0.

Source files
------------

// File: rtl/cv32e40p_apu_core_pkg.sv
// Shared APU interface constants plus the arbiter's requester ID type and the
// response watchdog threshold.
//   APU_*_CPU              : operand/opcode/flag widths of the APU interface
//   APU_ARB_TIMEOUT_CYCLES : cycles without a response before timeout_o sets
//   apu_req_id_t           : identifies requester 0 or 1
package cv32e40p_apu_core_pkg;

    localparam int unsigned APU_NARGS_CPU    = 3;
    localparam int unsigned APU_WOP_CPU      = 6;
    localparam int unsigned APU_NDSFLAGS_CPU = 15;
    localparam int unsigned APU_NUSFLAGS_CPU = 5;

    localparam int unsigned APU_ARB_TIMEOUT_CYCLES = 255;

    typedef logic apu_req_id_t;

endpackage

// File: rtl/cv32e40n_apu_arb_id_fifo.sv
// In-order FIFO of requester IDs for outstanding APU transactions.
//   clk, rst  : clock, asynchronous active-high reset
//   push, id  : store id at the tail (caller must not push while full)
//   pop       : drop the head (ignored while empty)
//   full      : DEPTH entries outstanding
//   empty     : nothing outstanding
//   head      : ID of the oldest outstanding transaction
module cv32e40n_apu_arb_id_fifo
    import cv32e40p_apu_core_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  apu_req_id_t id,
    input  logic        pop,
    output logic        full,
    output logic        empty,
    output apu_req_id_t head
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra bit so full and empty can be told apart.
    logic [AW:0]       wr_ptr_q, rd_ptr_q;
    apu_req_id_t [DEPTH-1:0] mem_q;

    logic do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= id;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cv32e40n_apu_arbiter.sv
// Round-robin arbiter sharing one APU between two requesters. Accepted
// requests record their owner in an in-order ID FIFO so each response is
// routed back to the requester that issued it.
//   clk_i, rst_i         : clock, asynchronous active-high reset
//   req_*_i / req_gnt_o  : per-requester request channel
//   req_rvalid_o         : per-requester response valid
//   req_result_o/flags_o : shared response data (passed through)
//   apu_*                : downstream APU request/response
//   spurious_o           : sticky, response arrived with nothing outstanding
//   timeout_o            : sticky response watchdog; only built when
//                          CV32E40N_APU_ARB_TIMEOUT_EN is defined, else tied 0
module cv32e40n_apu_arbiter
    import cv32e40p_apu_core_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [1:0][APU_NARGS_CPU-1:0][31:0]    req_operands_i,
    input  logic [1:0][APU_WOP_CPU-1:0]            req_op_i,
    input  logic [1:0][APU_NDSFLAGS_CPU-1:0]       req_flags_i,
    input  logic [1:0]                             req_req_i,
    output logic [1:0]                             req_gnt_o,
    output logic [1:0]                             req_rvalid_o,
    output logic [31:0]                            req_result_o,
    output logic [APU_NUSFLAGS_CPU-1:0]            req_flags_o,
    output logic [APU_NARGS_CPU-1:0][31:0]         apu_operands_o,
    output logic [APU_WOP_CPU-1:0]                 apu_op_o,
    output logic [APU_NDSFLAGS_CPU-1:0]            apu_flags_o,
    output logic                                   apu_req_o,
    input  logic                                   apu_gnt_i,
    input  logic                                   apu_rvalid_i,
    input  logic [31:0]                            apu_result_i,
    input  logic [APU_NUSFLAGS_CPU-1:0]            apu_flags_i,
    output logic                                   spurious_o,
    output logic                                   timeout_o
);

    apu_req_id_t last_q, winner, head;
    logic        full, empty, push, pop;
    logic        spurious_q;

    // On a tie the requester not granted last wins.
    assign winner = req_req_i[1] && (!req_req_i[0] || !last_q);

    assign apu_req_o = (|req_req_i) && !full && !rst_i;
    assign push      = apu_req_o && apu_gnt_i;
    assign pop       = apu_rvalid_i && !empty;

    always_comb begin
        req_gnt_o      = 2'b00;
        req_rvalid_o   = 2'b00;
        apu_operands_o = '0;
        apu_op_o       = '0;
        apu_flags_o    = '0;
        if (apu_req_o) begin
            apu_operands_o = req_operands_i[winner];
            apu_op_o       = req_op_i[winner];
            apu_flags_o    = req_flags_i[winner];
        end
        if (push) req_gnt_o[winner] = 1'b1;
        if (pop && !rst_i) req_rvalid_o[head] = 1'b1;
    end

    assign req_result_o = apu_result_i;
    assign req_flags_o  = apu_flags_i;

    cv32e40n_apu_arb_id_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_id_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .id    (winner),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q     <= 1'b1;
            spurious_q <= 1'b0;
        end else begin
            if (push) last_q <= winner;
            if (apu_rvalid_i && empty) spurious_q <= 1'b1;
        end
    end

    assign spurious_o = spurious_q;

`ifdef CV32E40N_APU_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(APU_ARB_TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(APU_ARB_TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q;

    always_comb begin
        cnt_d = cnt_q;
        if (empty || apu_rvalid_i) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (cnt_d == CNT_MAX) timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_cv32e40n_apu_arbiter.sv
// Directed self-checking bench for cv32e40n_apu_arbiter (FIFO_DEPTH = 4).
module tb_cv32e40n_apu_arbiter;
    import cv32e40p_apu_core_pkg::*;

    logic                                clk = 1'b0;
    logic                                rst;
    logic [1:0][APU_NARGS_CPU-1:0][31:0] req_operands;
    logic [1:0][APU_WOP_CPU-1:0]         req_op;
    logic [1:0][APU_NDSFLAGS_CPU-1:0]    req_flags;
    logic [1:0]                          req_req;
    logic [1:0]                          req_gnt;
    logic [1:0]                          req_rvalid;
    logic [31:0]                         req_result;
    logic [APU_NUSFLAGS_CPU-1:0]         req_flags_out;
    logic [APU_NARGS_CPU-1:0][31:0]      apu_operands;
    logic [APU_WOP_CPU-1:0]              apu_op;
    logic [APU_NDSFLAGS_CPU-1:0]         apu_flags;
    logic                                apu_req;
    logic                                apu_gnt;
    logic                                apu_rvalid;
    logic [31:0]                         apu_result;
    logic [APU_NUSFLAGS_CPU-1:0]         apu_flags_in;
    logic                                spurious;
    logic                                timeout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cv32e40n_apu_arbiter #(
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_operands_i (req_operands),
        .req_op_i       (req_op),
        .req_flags_i    (req_flags),
        .req_req_i      (req_req),
        .req_gnt_o      (req_gnt),
        .req_rvalid_o   (req_rvalid),
        .req_result_o   (req_result),
        .req_flags_o    (req_flags_out),
        .apu_operands_o (apu_operands),
        .apu_op_o       (apu_op),
        .apu_flags_o    (apu_flags),
        .apu_req_o      (apu_req),
        .apu_gnt_i      (apu_gnt),
        .apu_rvalid_i   (apu_rvalid),
        .apu_result_i   (apu_result),
        .apu_flags_i    (apu_flags_in),
        .spurious_o     (spurious),
        .timeout_o      (timeout)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and checks run mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        req_operands[0] = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        req_operands[1] = {32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC};
        req_op[0]    = 6'h05;
        req_op[1]    = 6'h2A;
        req_flags[0] = 15'h1234;
        req_flags[1] = 15'h4321;
        req_req      = 2'b00;
        apu_gnt      = 1'b0;
        apu_rvalid   = 1'b0;
        apu_result   = 32'h0;
        apu_flags_in = 5'h0;

        // Reset state
        #3;
        chk("rst_gnt", 128'(req_gnt), 128'(2'b00));
        chk("rst_apu_req", 128'(apu_req), 128'(1'b0));
        chk("rst_rvalid", 128'(req_rvalid), 128'(2'b00));
        chk("rst_spurious", 128'(spurious), 128'(1'b0));
        chk("rst_timeout", 128'(timeout), 128'(1'b0));
        tick();
        rst = 1'b0;

        // Single requester 0, response two cycles later
        req_req = 2'b01;
        apu_gnt = 1'b1;
        #3;
        chk("t1_apu_req", 128'(apu_req), 128'(1'b1));
        chk("t1_gnt", 128'(req_gnt), 128'(2'b01));
        chk("t1_operands", 128'(apu_operands),
            128'({32'h1111_1111, 32'h2222_2222, 32'h3333_3333}));
        chk("t1_op", 128'(apu_op), 128'(6'h05));
        chk("t1_flags", 128'(apu_flags), 128'(15'h1234));
        tick();
        req_req = 2'b00;
        #3;
        chk("t1_idle_req", 128'(apu_req), 128'(1'b0));
        chk("t1_idle_op", 128'(apu_op), 128'(6'h00));
        chk("t1_idle_rvalid", 128'(req_rvalid), 128'(2'b00));
        tick();
        apu_rvalid   = 1'b1;
        apu_result   = 32'hDEAD_BEEF;
        apu_flags_in = 5'h13;
        #3;
        chk("t1_rvalid", 128'(req_rvalid), 128'(2'b01));
        chk("t1_result", 128'(req_result), 128'(32'hDEAD_BEEF));
        chk("t1_rflags", 128'(req_flags_out), 128'(5'h13));
        tick();
        apu_rvalid = 1'b0;

        // Both requesting from reset: grants alternate, responses follow order
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req_req    = (i < 6) ? 2'b11 : 2'b00;
            apu_rvalid = (i >= 2);
            #3;
            if (i < 6) chk($sformatf("t2_gnt%0d", i), 128'(req_gnt),
                           128'((i % 2 == 0) ? 2'b01 : 2'b10));
            else       chk($sformatf("t2_gnt%0d", i), 128'(req_gnt), 128'(2'b00));
            if (i >= 2) chk($sformatf("t2_rv%0d", i), 128'(req_rvalid),
                            128'((i % 2 == 0) ? 2'b01 : 2'b10));
            tick();
        end
        apu_rvalid = 1'b0;
        #3;
        chk("t2_no_spurious", 128'(spurious), 128'(1'b0));

        // Fill the FIFO: full blocks grants, even in a pop cycle
        req_req = 2'b01;
        for (int i = 0; i < 4; i++) begin
            #3;
            chk($sformatf("t3_fill%0d", i), 128'(req_gnt), 128'(2'b01));
            tick();
        end
        #3;
        chk("t3_full_req", 128'(apu_req), 128'(1'b0));
        chk("t3_full_gnt", 128'(req_gnt), 128'(2'b00));
        tick();
        apu_rvalid = 1'b1;
        #3;
        chk("t3_pop_gnt", 128'(req_gnt), 128'(2'b00));
        chk("t3_pop_rv", 128'(req_rvalid), 128'(2'b01));
        tick();
        apu_rvalid = 1'b0;
        #3;
        chk("t3_resume_req", 128'(apu_req), 128'(1'b1));
        chk("t3_resume_gnt", 128'(req_gnt), 128'(2'b01));
        tick();
        req_req    = 2'b00;
        apu_rvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #3;
            chk($sformatf("t3_drain%0d", i), 128'(req_rvalid), 128'(2'b01));
            tick();
        end

        // Response with nothing outstanding
        #3;
        chk("t4_sp_rv", 128'(req_rvalid), 128'(2'b00));
        chk("t4_sp_pre", 128'(spurious), 128'(1'b0));
        tick();
        apu_rvalid = 1'b0;
        #3;
        chk("t4_sp_set", 128'(spurious), 128'(1'b1));
        tick();
        tick();
        #3;
        chk("t4_sp_sticky", 128'(spurious), 128'(1'b1));

        // Reset with three outstanding
        req_req = 2'b10;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk($sformatf("t6_g%0d", i), 128'(req_gnt), 128'(2'b10));
            tick();
        end
        rst     = 1'b1;
        req_req = 2'b11;
        #3;
        chk("t6_rst_gnt", 128'(req_gnt), 128'(2'b00));
        chk("t6_rst_req", 128'(apu_req), 128'(1'b0));
        chk("t6_rst_sp", 128'(spurious), 128'(1'b0));
        tick();
        rst        = 1'b0;
        req_req    = 2'b00;
        apu_rvalid = 1'b1;
        #3;
        chk("t6_empty_rv", 128'(req_rvalid), 128'(2'b00));
        tick();
        apu_rvalid = 1'b0;
        req_req    = 2'b11;
        #3;
        chk("t6_tie_gnt", 128'(req_gnt), 128'(2'b01));
        tick();
        req_req = 2'b00;

        // Watchdog: one transaction outstanding, no response
`ifdef CV32E40N_APU_ARB_TIMEOUT_EN
        repeat (254) tick();
        #3;
        chk("t5_to_before", 128'(timeout), 128'(1'b0));
        tick();
        #3;
        chk("t5_to_set", 128'(timeout), 128'(1'b1));
        repeat (5) tick();
        #3;
        chk("t5_to_sticky", 128'(timeout), 128'(1'b1));
`else
        repeat (300) tick();
        #3;
        chk("t5_to_off", 128'(timeout), 128'(1'b0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
